dmem_responder: RTL

Responder end of the data-memory request/response interface driven by the pipelined CPU's MEM stage. Accepts one word read or write request at a time over a valid/ready handshake. Inserts a parameterised number of wait states, then returns read data or a write acknowledgement, with an error flag, over a second valid/ready handshake. Replaces the zero-latency data memory so the pipeline's memory-stall path can be exercised against realistic latency.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_array.sv | 20 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, word size and the address legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Legal only if word-aligned and the full word index falls inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] == 2'b00) && (word_idx < depth_words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and synchronous read; contents are not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, then returns
// read data / write ack with an error flag. The array is accessed on the edge entering RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             clr,
  dmem_responder_if.slave bus
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int BYTE_BITS = $clog2(WORD_BYTES);
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        err_q;
  logic        rdata_en_q;

  logic             accept;
  logic             enter_resp;
  logic             src_we;
  logic [31:0]      src_addr;
  logic [31:0]      src_wdata;
  logic             src_ok;
  logic             arr_we;
  logic [IDX_W-1:0] arr_idx;
  logic [31:0]      arr_rdata;

  assign accept = ready_q && bus.req_valid;

  // With zero wait states the array is hit on the acceptance edge, straight from the bus.
  always_comb begin
    src_we    = we_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state == IDLE) begin
      src_we    = bus.req_we;
      src_addr  = bus.req_addr;
      src_wdata = bus.req_wdata;
    end
  end

  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (wait_cnt == WS_LAST));
  assign src_ok  = addr_ok(src_addr, DEPTH_WORDS);
  assign arr_we  = !clr && enter_resp && src_we && src_ok;
  assign arr_idx = src_addr[IDX_W+BYTE_BITS-1:BYTE_BITS];

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (src_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == WS_LAST) state <= RESP;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            rdata_en_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        err_q      <= !src_ok;
        rdata_en_q <= src_ok && !src_we;
      end
    end
  end

  // Array output only holds read data during a good read response; everything else reads as 0.
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_en_q ? arr_rdata : 32'h0;

endmodule
